pad_seq_ctrl: RTL and testbench
===============================

PAD_SEQ_CTRL -- requirements
Module: pad_seq_ctrl

Interface
REQ-001 SHALL have parameter BUSW, 32, PDI word width in bits (4 bytes per word).
REQ-002 SHALL have parameter CNTW, 2, width of the word counter (4 words per 128-bit block).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to sequence one block; sampled only in IDLE.
REQ-006 SHALL have port blk_len  input  5  valid bytes in the block, 0..16; values >16 treated as 16; captured on an accepted start.
REQ-007 SHALL have port blk_last  input  1  block is the final block of its segment; captured on an accepted start.
REQ-008 SHALL have port share_en  input  1  masked mode (pad bytes from randomness); captured on an accepted start.
REQ-009 SHALL have port pdi_valid  input  1  PDI word available.
REQ-010 SHALL have port pdi_ready  output  1  PDI word consumed this cycle when high with pdi_valid.
REQ-011 SHALL have port core_ready  input  1  downstream accepts the completed block.
REQ-012 SHALL have port cnt  output  CNTW  word index driven to the padding mux.
REQ-013 SHALL have port seglen  output  4  byte count driven to the padding mux.
REQ-014 SHALL have port pad  output  1  padding enable to the padding mux.
REQ-015 SHALL have port last  output  1  length-byte insertion enable to the padding mux.
REQ-016 SHALL have port share  output  1  masked-mode select to the padding mux.
REQ-017 SHALL have port word_we  output  1  padded word written into the block buffer at index cnt this cycle.
REQ-018 SHALL have port blk_valid  output  1  complete 16-byte block held for the core.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement states IDLE, FETCH, FILL, HOLD.
REQ-021 SHALL, in IDLE with start=1, capture len=min(blk_len,16), blk_last, share_en, clear cnt to 0 and go to FETCH if nwords>0, else FILL; nwords=ceil(len/4) (0..4).
REQ-022 SHALL drive pad=1 and seglen=len[3:0] when captured len<16; pad=0 and seglen=0 when len=16.
REQ-023 SHALL, in FETCH, drive pdi_ready=1 and word_we=pdi_valid; stall (no cnt change) while pdi_valid=0.
REQ-024 SHALL increment cnt on every word_we; after the write at cnt=3 go to HOLD; after the write at cnt=nwords-1 (cnt<3) go to FILL.
REQ-025 SHALL, in FILL, drive pdi_ready=0 and word_we=1 every cycle (one padded word per cycle, no PDI consumption).
REQ-026 SHALL drive last = pad AND blk_last AND (cnt=3), so the length byte appears only in the final byte of the block.
REQ-027 SHALL drive share = captured share_en in FETCH and FILL, 0 otherwise.
REQ-028 SHALL, in HOLD, drive blk_valid=1, word_we=0, pdi_ready=0; on core_ready=1 return to IDLE (blk_valid low next cycle).
REQ-029 SHALL ignore start outside IDLE; captured fields SHALL not change until the next accepted start.
REQ-030 SHALL drive pdi_ready=0 and word_we=0 in IDLE and HOLD.
REQ-031 SHALL give latency: len=16, pdi_valid continuously high, start at cycle 0 -> word_we cycles 1..4, blk_valid from cycle 5.
REQ-032 SHALL complete any block in exactly 4 word_we pulses regardless of len.
REQ-033 SHALL allow start on the same cycle blk_valid drops (IDLE reached) with no lost cycle beyond the IDLE cycle.

Reset
REQ-034 SHALL, on rst_n=0 at any time (including mid-block), go to IDLE asynchronously with cnt=0, seglen=0, pad=0, last=0, share=0, pdi_ready=0, word_we=0, blk_valid=0, busy=0, captured fields cleared.
REQ-035 SHALL resume on the first rising clk edge after rst_n rises, with start sampled from that edge.

Verification
REQ-036 SHALL cover: len=16, blk_last=1, valid always high -> 4 word_we with cnt 0..3, pad=0, last=0 throughout, blk_valid at cycle 5.
REQ-037 SHALL cover: len=5, blk_last=1, share_en=0 -> 2 PDI words consumed, 2 FILL cycles, seglen=5, pad=1, last=1 only at cnt=3.
REQ-038 SHALL cover: len=0, blk_last=1 -> pdi_ready never high, 4 FILL writes, seglen=0, last=1 at cnt=3.
REQ-039 SHALL cover: len=12, pdi_valid low 3 cycles after first word -> cnt holds at 1 during the stall, block completes after 3 extra cycles.
REQ-040 SHALL cover: core_ready held low 10 cycles in HOLD with start pulsing -> blk_valid stays 1, start ignored, no word_we.
REQ-041 SHALL cover: rst_n low during FETCH at cnt=2 -> all outputs at reset values immediately; new start with len=16 afterwards completes normally.

Source files
------------

// File: rtl/pad_seq_ctrl.sv
`default_nettype none
// ============================================================================
// pad_seq_ctrl : sequences PDI words and padded fill words into one 128-bit
//                block, then holds the block until the core accepts it.
// Revision     : 1.0
// ============================================================================
module pad_seq_ctrl #(
  parameter int BUSW = 32,
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      blk_len,
  input  logic            blk_last,
  input  logic            share_en,
  input  logic            pdi_valid,
  output logic            pdi_ready,
  input  logic            core_ready,
  output logic [CNTW-1:0] cnt,
  output logic [3:0]      seglen,
  output logic            pad,
  output logic            last,
  output logic            share,
  output logic            word_we,
  output logic            blk_valid,
  output logic            busy
);

  localparam int         BYTES_W = BUSW / 8;
  localparam int         BSHIFT  = $clog2(BYTES_W);
  localparam logic [4:0] FULL_LEN = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  logic [4:0]      len_q, len_nxt;
  logic            blk_last_q, blk_last_nxt;
  logic            share_q, share_nxt;

  logic [4:0]      len_in;
  logic [5:0]      nwords_in;
  logic [5:0]      nwords_q;
  logic            cnt_max;
  logic            cnt_at_last_fetch;
  logic            active;

  // Number of bus words that carry real data for a byte length.
  function automatic logic [5:0] words_of(input logic [4:0] l);
    return ({1'b0, l} + 6'(BYTES_W - 1)) >> BSHIFT;
  endfunction

  assign len_in            = (blk_len > FULL_LEN) ? FULL_LEN : blk_len;
  assign nwords_in         = words_of(len_in);
  assign nwords_q          = words_of(len_q);
  assign cnt_max           = (cnt_q == {CNTW{1'b1}});
  assign cnt_at_last_fetch = ({{(6-CNTW){1'b0}}, cnt_q} == (nwords_q - 6'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      blk_last_q <= 1'b0;
      share_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt_q      <= cnt_nxt;
      len_q      <= len_nxt;
      blk_last_q <= blk_last_nxt;
      share_q    <= share_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt_q;
    len_nxt      = len_q;
    blk_last_nxt = blk_last_q;
    share_nxt    = share_q;
    pdi_ready    = 1'b0;
    word_we      = 1'b0;
    blk_valid    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          len_nxt      = len_in;
          blk_last_nxt = blk_last;
          share_nxt    = share_en;
          cnt_nxt      = '0;
          state_nxt    = (nwords_in != 6'd0) ? FETCH : FILL;
        end
      end
      FETCH: begin
        pdi_ready = 1'b1;
        word_we   = pdi_valid;
        if (pdi_valid) begin
          cnt_nxt = cnt_q + 1'b1;
          if (cnt_max) begin
            state_nxt = HOLD;
          end else if (cnt_at_last_fetch) begin
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        // Pure padding words: written one per cycle without touching the PDI.
        word_we = 1'b1;
        cnt_nxt = cnt_q + 1'b1;
        if (cnt_max) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        blk_valid = 1'b1;
        if (core_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Mux controls are only meaningful while words are being written.
  assign active = (state == FETCH) || (state == FILL);
  assign pad    = active && (len_q < FULL_LEN);
  assign seglen = pad ? len_q[3:0] : 4'd0;
  assign last   = pad && blk_last_q && cnt_max;
  assign share  = active && share_q;
  assign busy   = (state != IDLE);
  assign cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_seq_ctrl.sv
`default_nettype none
// tb_pad_seq_ctrl : table-driven blocks, directed reset/hold corners and random
// traffic, all compared cycle by cycle against a word-count model.
module tb_pad_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] blk_len = 5'd0;
  logic       blk_last = 1'b0;
  logic       share_en = 1'b0;
  logic       pdi_valid = 1'b0;
  logic       core_ready = 1'b0;
  logic       pdi_ready, pad, last, share, word_we, blk_valid, busy;
  logic [1:0] cnt;
  logic [3:0] seglen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pad_seq_ctrl #(.BUSW(32), .CNTW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .blk_len    (blk_len),
    .blk_last   (blk_last),
    .share_en   (share_en),
    .pdi_valid  (pdi_valid),
    .pdi_ready  (pdi_ready),
    .core_ready (core_ready),
    .cnt        (cnt),
    .seglen     (seglen),
    .pad        (pad),
    .last       (last),
    .share      (share),
    .word_we    (word_we),
    .blk_valid  (blk_valid),
    .busy       (busy)
  );

  // Reference model: a block is "words written so far" out of four.
  bit m_active, m_hold, m_blast, m_share;
  int m_len, m_nw, m_wd;

  typedef struct {
    logic [4:0] len;
    bit         blast;
    bit         shr;
    int         stall;
    int         hwait;
    int         e_pdi;
    int         e_fill;
    int         e_last;
    int         e_bv;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_hold = 0; m_blast = 0; m_share = 0;
    m_len = 0; m_nw = 0; m_wd = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_hold   = 0;
        m_wd     = 0;
        m_len    = (blk_len > 16) ? 16 : int'(blk_len);
        m_nw     = (m_len + 3) / 4;
        m_blast  = blk_last;
        m_share  = share_en;
      end
    end else if (!m_hold) begin
      if (m_wd >= m_nw || pdi_valid) begin
        m_wd++;
        if (m_wd == 4) m_hold = 1;
      end
    end else if (core_ready) begin
      m_active = 0;
    end
  endtask

  task automatic check_outputs();
    bit fill_ph, fetching, e_pad;
    fill_ph  = m_active && !m_hold;
    fetching = fill_ph && (m_wd < m_nw);
    e_pad    = fill_ph && (m_len < 16);
    chk("busy", busy, m_active);
    chk("pdi_ready", pdi_ready, fetching);
    chk("word_we", word_we, fill_ph && (fetching ? pdi_valid : 1'b1));
    chk("cnt", cnt, m_wd % 4);
    chk("pad", pad, e_pad);
    chk("seglen", seglen, e_pad ? m_len : 0);
    chk("last", last, e_pad && m_blast && (m_wd == 3));
    chk("share", share, fill_ph && m_share);
    chk("blk_valid", blk_valid, m_active && m_hold);
  endtask

  task automatic finish_cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    finish_cycle();
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int n_pdi = 0, n_fill = 0, n_last = 0, n_hold = 0;
    int first_bv = -1, stall_left = 0, k = 0;
    bit done = 0;
    start = 1'b1; blk_len = v.len; blk_last = v.blast; share_en = v.shr;
    pdi_valid = 1'b1; core_ready = 1'($urandom_range(0, 1));
    tick();
    while (!done && k < 60) begin
      k++;
      pdi_valid = (stall_left > 0) ? 1'b0 : 1'b1;
      blk_len   = 5'($urandom_range(0, 31));
      blk_last  = 1'($urandom_range(0, 1));
      share_en  = 1'($urandom_range(0, 1));
      if (blk_valid) begin
        core_ready = (n_hold >= v.hwait);
        start      = core_ready ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        core_ready = 1'($urandom_range(0, 1));
        start      = 1'($urandom_range(0, 1));
      end
      #1;
      if (pdi_ready && pdi_valid) begin
        n_pdi++;
        if (n_pdi == 1) stall_left = v.stall;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      if (word_we && !pdi_ready) n_fill++;
      if (last) n_last++;
      if (blk_valid) begin
        if (first_bv < 0) first_bv = k;
        n_hold++;
        if (core_ready) done = 1;
      end
      finish_cycle();
    end
    start = 1'b0; core_ready = 1'b0;
    chk({tag, "_completed"}, done, 1);
    chk({tag, "_pdi_words"}, n_pdi, v.e_pdi);
    chk({tag, "_fill_words"}, n_fill, v.e_fill);
    chk({tag, "_last_pulses"}, n_last, v.e_last);
    chk({tag, "_blk_valid_cycle"}, first_bv, v.e_bv);
    chk({tag, "_hold_cycles"}, n_hold, v.hwait + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            len    bl sh st hw pdi fill last bv
    vecs[0] = '{5'd16, 1, 0, 0, 0, 4, 0, 0, 5};
    vecs[1] = '{5'd5,  1, 0, 0, 0, 2, 2, 1, 5};
    vecs[2] = '{5'd0,  1, 0, 0, 0, 0, 4, 1, 5};
    vecs[3] = '{5'd12, 0, 0, 3, 0, 3, 1, 0, 8};
    vecs[4] = '{5'd20, 0, 1, 0, 0, 4, 0, 0, 5};
    vecs[5] = '{5'd1,  0, 1, 0, 2, 1, 3, 0, 5};
    vecs[6] = '{5'd13, 1, 0, 0, 10, 4, 0, 1, 5};
    vecs[7] = '{5'd4,  1, 1, 2, 0, 1, 3, 1, 5};

    model_reset();
    @(negedge clk);
    start = 1'b1; blk_len = 5'd16;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_cnt", cnt, 0);
    rst_n = 1'b1; start = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of fetching, at word index 2.
    start = 1'b1; blk_len = 5'd16; blk_last = 1'b1; share_en = 1'b1;
    pdi_valid = 1'b1; core_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1;
    chk("pre_reset_cnt", cnt, 2);
    chk("pre_reset_share", share, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("async_reset_word_we", word_we, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(vecs[0], "after_reset");

    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      blk_len    = 5'($urandom_range(0, 20));
      blk_last   = 1'($urandom_range(0, 1));
      share_en   = 1'($urandom_range(0, 1));
      pdi_valid  = ($urandom_range(0, 3) != 0);
      core_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
